// File: rtl/rs_bank_pkg.sv
// rs_bank_pkg: shared tag/entry types and sizing constants for the reservation-station banks.
package rs_bank_pkg;

  localparam int PHYS_TAG_W  = 6;
  localparam int OPCODE_W    = 8;
  localparam int RS_ALU_SZ   = 8;
  localparam int NUM_FU_ALU  = 2;
  localparam int CDB_SZ      = 2;
  localparam int DISPATCH_SZ = 2;

  typedef logic [PHYS_TAG_W-1:0] phys_tag_t;

  typedef struct packed {
    logic                valid;
    phys_tag_t           src1_tag;
    logic                src1_ready;
    phys_tag_t           src2_tag;
    logic                src2_ready;
    phys_tag_t           dest_tag;
    logic [OPCODE_W-1:0] opcode;
  } rs_entry_t;

  // Marks either source ready when its tag matches a completing destination tag.
  function automatic rs_entry_t wake_entry(input rs_entry_t e, input phys_tag_t tag);
    rs_entry_t r;
    r = e;
    if (e.src1_tag == tag) r.src1_ready = 1'b1;
    if (e.src2_tag == tag) r.src2_ready = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/rs_free_selector.sv
// rs_free_selector: picks up to DISPATCH_WIDTH free slots, lowest index first,
// as a cascade of lowest-set-bit pickers that each mask out the previous pick.
module rs_free_selector
  import rs_bank_pkg::*;
#(
  parameter int RS_SZ          = RS_ALU_SZ,
  parameter int DISPATCH_WIDTH = DISPATCH_SZ
) (
  input  logic [RS_SZ-1:0]                      free_mask,
  output logic [DISPATCH_WIDTH-1:0][RS_SZ-1:0]  sel_onehot,
  output logic [DISPATCH_WIDTH-1:0]             sel_valid
);

  logic [RS_SZ-1:0] remaining;

  // Cascaded lowest-set-bit extraction; select k is the k-th lowest free slot.
  always_comb begin
    remaining  = free_mask;
    sel_onehot = '0;
    sel_valid  = '0;
    for (int p = 0; p < DISPATCH_WIDTH; p++) begin
      sel_onehot[p] = remaining & ~(remaining - RS_SZ'(1));
      sel_valid[p]  = |remaining;
      remaining     = remaining & ~sel_onehot[p];
    end
  end

endmodule

// File: rtl/rs_bank.sv
// rs_bank: one reservation-station bank; accepts dispatches into free slots,
// wakes sources from CDB broadcasts and frees slots named by the issue stage.
// Optional macro RS_DISPATCH_BYPASS_EN: also wake a dispatching entry from the
// same-cycle CDB broadcasts so a result produced in the dispatch cycle is not lost.
module rs_bank
  import rs_bank_pkg::*;
#(
  parameter int RS_SZ          = RS_ALU_SZ,
  parameter int DISPATCH_WIDTH = DISPATCH_SZ,
  parameter int NUM_CLEAR      = NUM_FU_ALU,
  parameter int CDB_WIDTH      = CDB_SZ
) (
  input  logic                                     clock,
  input  logic                                     reset,
  input  logic                                     mispredict,
  input  logic      [DISPATCH_WIDTH-1:0]           disp_valid,
  input  rs_entry_t [DISPATCH_WIDTH-1:0]           disp_entry,
  input  logic      [CDB_WIDTH-1:0]                cdb_valid,
  input  phys_tag_t [CDB_WIDTH-1:0]                cdb_tag,
  input  logic      [NUM_CLEAR-1:0]                clear_valid,
  input  logic      [NUM_CLEAR-1:0][$clog2(RS_SZ)-1:0] clear_idx,
  output rs_entry_t [RS_SZ-1:0]                    entries,
  output logic      [$clog2(RS_SZ+1)-1:0]          free_count,
  output logic                                     full
);

  localparam int CNT_W  = $clog2(RS_SZ + 1);
  localparam int RANK_W = (DISPATCH_WIDTH > 1) ? $clog2(DISPATCH_WIDTH) : 1;

  rs_entry_t [RS_SZ-1:0]                   entries_q;
  rs_entry_t [RS_SZ-1:0]                   entries_d;
  logic      [RS_SZ-1:0]                   valid_mask;
  logic      [RS_SZ-1:0]                   free_mask;
  logic      [DISPATCH_WIDTH-1:0][RS_SZ-1:0] sel_onehot;
  logic      [DISPATCH_WIDTH-1:0]          sel_valid;
  logic      [DISPATCH_WIDTH-1:0]          dropped;
  logic      [RANK_W-1:0]                  rank;

  // Gather registered valid bits; slot choice never looks at this cycle's clears.
  always_comb begin
    valid_mask = '0;
    for (int i = 0; i < RS_SZ; i++) valid_mask[i] = entries_q[i].valid;
  end

  assign free_mask = ~valid_mask;

  rs_free_selector #(
    .RS_SZ          (RS_SZ),
    .DISPATCH_WIDTH (DISPATCH_WIDTH)
  ) u_free_selector (
    .free_mask  (free_mask),
    .sel_onehot (sel_onehot),
    .sel_valid  (sel_valid)
  );

  // Free count from registered state only, so the dispatcher sees no comb path back.
  always_comb begin
    free_count = CNT_W'(RS_SZ);
    for (int i = 0; i < RS_SZ; i++) begin
      if (valid_mask[i]) free_count = free_count - CNT_W'(1);
    end
  end

  assign full    = (free_count == '0);
  assign entries = entries_q;

  // Next state in priority order: flush over clear over wakeup over dispatch write.
  always_comb begin
    entries_d = entries_q;
    dropped   = '0;
    rank      = '0;

    for (int f = 0; f < NUM_CLEAR; f++) begin
      if (clear_valid[f]) entries_d[clear_idx[f]] = '0;
    end

    for (int i = 0; i < RS_SZ; i++) begin
      if (entries_d[i].valid) begin
        for (int c = 0; c < CDB_WIDTH; c++) begin
          if (cdb_valid[c]) entries_d[i] = wake_entry(entries_d[i], cdb_tag[c]);
        end
      end
    end

    for (int p = 0; p < DISPATCH_WIDTH; p++) begin
      if (disp_valid[p]) begin
        if (sel_valid[rank]) begin
          for (int i = 0; i < RS_SZ; i++) begin
            if (sel_onehot[rank][i]) begin
              entries_d[i]       = disp_entry[p];
              entries_d[i].valid = 1'b1;
`ifdef RS_DISPATCH_BYPASS_EN
              for (int c = 0; c < CDB_WIDTH; c++) begin
                if (cdb_valid[c]) entries_d[i] = wake_entry(entries_d[i], cdb_tag[c]);
              end
`else
`endif
            end
          end
        end else begin
          dropped[p] = 1'b1;
        end
        rank = rank + RANK_W'(1);
      end
    end

    if (mispredict) entries_d = '0;
  end

  // Entry array register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) entries_q <= '0;
    else       entries_q <= entries_d;
  end

  // Simulation-only check that the dispatcher never exceeds the free slots.
  always_ff @(posedge clock) begin
    if (!reset && !mispredict) begin
      assert (dropped == '0);
    end
  end

endmodule

// File: doc/rs_bank.md
Name: rs_bank

Overview:
One reservation-station bank per FU category (ALU, MULT, BRANCH, MEM), sitting directly upstream of the issue stage.
- Accepts up to DISPATCH_WIDTH renamed instructions per cycle into free slots.
- Wakes up source operands from CDB tag broadcasts.
- Exposes its registered entry array to the issue stage as one field of RS_BANKS.
- Frees slots named by the issue stage's clear signals.

Parameters:
RS_SZ, 8, number of entries in the bank (`RS_ALU_SZ` etc. at instantiation)
DISPATCH_WIDTH, 2, dispatch ports per cycle
NUM_CLEAR, 2, clear ports; equals the FU count of this category
CDB_WIDTH, 2, CDB broadcast ports per cycle

Ports:
clock  in  1  system clock; all state updates on posedge
reset  in  1  synchronous, active-high reset
mispredict  in  1  synchronous flush, same effect as reset
disp_valid  in  DISPATCH_WIDTH  dispatch request per port
disp_entry  in  DISPATCH_WIDTH x RS_ENTRY  renamed instruction; src*_ready supplied by rename
cdb_valid  in  CDB_WIDTH  broadcast valid per port
cdb_tag  in  CDB_WIDTH x PHYS_TAG  completing physical destination tag
clear_valid  in  NUM_CLEAR  issue-stage clear valid per FU
clear_idx  in  NUM_CLEAR x RS_IDX  local bank index to free
entries  out  RS_SZ x RS_ENTRY  registered entry array to the issue stage
free_count  out  $clog2(RS_SZ+1)  RS_SZ minus popcount of registered valid bits
full  out  1  free_count == 0

Behaviour:
- Reset or mispredict: all entries become '0 at the next edge. Resulting outputs: entries = '0, free_count = RS_SZ, full = 0. Inputs are ignored in that cycle.
- Slot selection: combinational, from registered valid bits only.
  - Dispatch port k (counting only asserted ports, lowest port first) takes the k-th lowest-index free slot.
  - Slots cleared in the same cycle are not reusable until the next cycle.
- Over-dispatch: the dispatcher must respect free_count.
  - Valid dispatches beyond the available free slots are dropped.
  - A simulation-only assertion flags any such drop.
- Dispatch latency: an entry written at edge t is visible on entries after edge t. It can be issued at the earliest in cycle t+1.
- Wakeup: for each valid entry and each asserted cdb port, if src1_tag == cdb_tag, set src1_ready at the next edge; src2 likewise.
  - Multiple matches are harmless (OR).
  - Already-ready sources are unaffected.
- Clear: clear_valid[f] invalidates entry clear_idx[f] at the next edge.
  - Clearing an invalid entry: no-op.
  - Duplicate indices across clear ports: single clear.
- Simultaneous clear and wakeup on the same entry: clear wins; the entry ends invalid.
- Simultaneous clear and dispatch: cannot collide, since dispatch only targets slots that are free in the registered state.
- Order of next-state evaluation: flush > clear > wakeup > dispatch write. All four are evaluated in one always_comb, then registered.
- free_count and full are purely combinational from registered state. They carry no dependence on the current cycle's inputs, so there is no comb loop with the dispatcher.

Optional Feature:
Macro: RS_DISPATCH_BYPASS_EN.
- Defined: a dispatched instruction's src tags are compared against the same-cycle cdb broadcasts. On a match, the stored src*_ready is set, so a value broadcast in the dispatch cycle is not missed.
- Undefined: stored ready bits are exactly disp_entry's. Rename must then already fold same-cycle CDB results into the ready bits.

Decomposition:
- Existing shared header sys_defs.svh holds:
  - RS_ENTRY: valid, src1/src2 tags and ready bits, dest_tag, opcode payload.
  - PHYS_TAG, RS_IDX.
  - `RS_*_SZ`, `NUM_FU_*`, `CDB_SZ`.
- New in the same header: none required.
- One sub-module: rs_free_selector, parameterized by RS_SZ and DISPATCH_WIDTH.
  - Input: free mask. Output: DISPATCH_WIDTH one-hot slot selects plus per-select valid.
  - Implemented as cascaded lowest-set-bit pickers, each masking out the prior pick.

Test Plan:
- Reset, then dispatch 2 entries with all sources ready -> entries[0], entries[1] valid next cycle; free_count = 6 (RS_SZ = 8).
- Fill 8 entries over 4 cycles, then assert disp_valid = 2'b11 -> full = 1; no entry changes; assertion fires.
- Entry 3 waiting on src1_tag = 17; cdb_valid[1] = 1, cdb_tag[1] = 17 -> entries[3].src1_ready = 1 after the edge; src2_ready unchanged.
- clear_valid = 2'b11, clear_idx = {5,2} while cdb wakes entry 2 -> entries 2 and 5 invalid; free_count rises by 2 the next cycle.
- Bank holding 6 valid entries, pulse mispredict with disp_valid = 1 -> all entries '0; free_count = 8; the dispatch is not written.
- Macro defined: dispatch an entry with src2_tag = 9, src2_ready = 0, while cdb_tag[0] = 9 -> stored src2_ready = 1. Macro undefined: stored src2_ready = 0.
